// File: rtl/boton_antirrebote.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM and short/long press
// classification, producing a debounced level and single-cycle press events.
module boton_antirrebote #(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int LARGO_CICLOS    = 20,
    parameter bit ACTIVO_BAJO     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton_in,
    output logic presionado,
    output logic pulso_corto,
    output logic pulso_largo
);

    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam int HW = $clog2(LARGO_CICLOS + 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CICLOS - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(LARGO_CICLOS - 1);
    localparam logic [HW-1:0] HOLD_SAT   = HW'(LARGO_CICLOS);

    typedef enum logic [2:0] {
        REPOSO, DEB_PRES, PRESIONADO, LARGO, DEB_SOLT
    } estado_t;

    estado_t       state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [DW-1:0] cnt_deb_q, cnt_deb_d;
    logic [HW-1:0] cnt_hold_q, cnt_hold_d;
    logic          corto_q, corto_d;
    logic          pres_q, pres_d;
    logic          corto_pulse_q, corto_pulse_d;
    logic          largo_pulse_q, largo_pulse_d;
    logic          b_s;

    // Normalise polarity so that 1 always means "pressed" inside the block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= boton_in ^ ACTIVO_BAJO;
            sync2_q <= sync1_q;
        end
    end

    assign b_s = sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= REPOSO;
            cnt_deb_q     <= '0;
            cnt_hold_q    <= '0;
            corto_q       <= 1'b0;
            pres_q        <= 1'b0;
            corto_pulse_q <= 1'b0;
            largo_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_deb_q     <= cnt_deb_d;
            cnt_hold_q    <= cnt_hold_d;
            corto_q       <= corto_d;
            pres_q        <= pres_d;
            corto_pulse_q <= corto_pulse_d;
            largo_pulse_q <= largo_pulse_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_deb_d     = cnt_deb_q;
        cnt_hold_d    = cnt_hold_q;
        corto_d       = corto_q;
        pres_d        = pres_q;
        corto_pulse_d = 1'b0;
        largo_pulse_d = 1'b0;
        unique case (state_q)
            REPOSO: begin
                if (b_s) begin
                    state_d   = DEB_PRES;
                    cnt_deb_d = DW'(1);
                end
            end
            DEB_PRES: begin
                if (!b_s) begin
                    state_d = REPOSO;
                end else if (cnt_deb_q == DEB_LAST) begin
                    state_d    = PRESIONADO;
                    pres_d     = 1'b1;
                    cnt_hold_d = '0;
                end else begin
                    cnt_deb_d = cnt_deb_q + DW'(1);
                end
            end
            PRESIONADO: begin
                if (!b_s) begin
                    state_d   = DEB_SOLT;
                    cnt_deb_d = DW'(1);
                    corto_d   = 1'b1;
                end else if (cnt_hold_q == HOLD_LAST) begin
                    state_d       = LARGO;
                    cnt_hold_d    = HOLD_SAT;
                    largo_pulse_d = 1'b1;
                end else begin
                    cnt_hold_d = cnt_hold_q + HW'(1);
                end
            end
            LARGO: begin
                if (!b_s) begin
                    state_d   = DEB_SOLT;
                    cnt_deb_d = DW'(1);
                    corto_d   = 1'b0;
                end
            end
            DEB_SOLT: begin
                // A release glitch resumes the press with the hold count untouched.
                if (b_s) begin
                    state_d = corto_q ? PRESIONADO : LARGO;
                end else if (cnt_deb_q == DEB_LAST) begin
                    state_d       = REPOSO;
                    pres_d        = 1'b0;
                    corto_pulse_d = corto_q;
                    corto_d       = 1'b0;
                end else begin
                    cnt_deb_d = cnt_deb_q + DW'(1);
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    assign presionado  = pres_q;
    assign pulso_corto = corto_pulse_q;
    assign pulso_largo = largo_pulse_q;

endmodule

// File: tb/tb_boton_antirrebote.sv
// Directed bench for boton_antirrebote (DEBOUNCE=4, LARGO=20, active-low pin).
module tb_boton_antirrebote;

    logic clk = 1'b0;
    logic reset;
    logic boton_in;
    logic presionado, pulso_corto, pulso_largo;

    int vectors = 0;
    int miscompares = 0;

    int edge_n = 0;
    int n_rise, n_fall, n_corto, n_largo, n_both;
    int rise_edge, fall_edge, corto_edge, largo_edge;
    logic prev_pres = 1'b0;

    boton_antirrebote #(
        .DEBOUNCE_CICLOS(4),
        .LARGO_CICLOS(20),
        .ACTIVO_BAJO(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .boton_in(boton_in),
        .presionado(presionado),
        .pulso_corto(pulso_corto),
        .pulso_largo(pulso_largo)
    );

    always #5 clk = ~clk;

    task automatic clear_stats();
        n_rise = 0; n_fall = 0; n_corto = 0; n_largo = 0; n_both = 0;
        rise_edge = -1; fall_edge = -1; corto_edge = -1; largo_edge = -1;
    endtask

    // Advance one edge and record output events, sampling 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        if (presionado && !prev_pres) begin n_rise++; rise_edge = edge_n; end
        if (!presionado && prev_pres) begin n_fall++; fall_edge = edge_n; end
        if (pulso_corto) begin n_corto++; corto_edge = edge_n; end
        if (pulso_largo) begin n_largo++; largo_edge = edge_n; end
        if (pulso_corto && pulso_largo) n_both++;
        prev_pres = presionado;
    endtask

    task automatic drive(input logic pin, input int n);
        boton_in = pin;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        logic [2:0] outs;
        reset = 1'b1;
        boton_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            boton_in = i[0];
            @(posedge clk); #1;
            outs = {presionado, pulso_corto, pulso_largo};
            vectors++;
            if (outs !== 3'b000) begin
                miscompares++;
                $display("FAIL reset_outs cycle %0d: got %b want 000", i, outs);
            end
        end
        boton_in = 1'b1;
        reset = 1'b0;
        prev_pres = 1'b0;
        clear_stats();
        drive(1'b1, 50);
        vectors++;
        if (n_rise != 0 || n_corto != 0 || n_largo != 0 || presionado !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet: rises=%0d corto=%0d largo=%0d pres=%b want 0 0 0 0",
                     n_rise, n_corto, n_largo, presionado);
        end
    endtask

    task automatic test_short_press();
        int s, r;
        clear_stats();
        s = edge_n;
        drive(1'b0, 10);
        vectors++;
        if (rise_edge != s + 6) begin
            miscompares++;
            $display("FAIL short_rise_latency: got %0d want %0d", rise_edge - s, 6);
        end
        r = edge_n;
        drive(1'b1, 15);
        vectors++;
        if (fall_edge != r + 6) begin
            miscompares++;
            $display("FAIL short_fall_latency: got %0d want %0d", fall_edge - r, 6);
        end
        vectors++;
        if (n_corto != 1 || corto_edge != fall_edge) begin
            miscompares++;
            $display("FAIL short_pulse: count=%0d at %0d want 1 at %0d", n_corto, corto_edge, fall_edge);
        end
        vectors++;
        if (n_largo != 0) begin
            miscompares++;
            $display("FAIL short_no_largo: got %0d want 0", n_largo);
        end
    endtask

    task automatic test_long_press();
        int s, r;
        clear_stats();
        s = edge_n;
        drive(1'b0, 40);
        vectors++;
        if (rise_edge != s + 6) begin
            miscompares++;
            $display("FAIL long_rise_latency: got %0d want %0d", rise_edge - s, 6);
        end
        vectors++;
        if (n_largo != 1 || largo_edge != rise_edge + 20) begin
            miscompares++;
            $display("FAIL long_pulse: count=%0d offset=%0d want 1 offset 20",
                     n_largo, largo_edge - rise_edge);
        end
        r = edge_n;
        drive(1'b1, 15);
        vectors++;
        if (n_corto != 0 || fall_edge != r + 6 || n_largo != 1) begin
            miscompares++;
            $display("FAIL long_release: corto=%0d fall=%0d largo=%0d want 0 6 1",
                     n_corto, fall_edge - r, n_largo);
        end
    endtask

    task automatic test_glitches();
        for (int w = 1; w <= 3; w++) begin
            clear_stats();
            drive(1'b0, w);
            drive(1'b1, 12);
            vectors++;
            if (n_rise != 0 || n_corto != 0 || n_largo != 0) begin
                miscompares++;
                $display("FAIL glitch_%0d: rises=%0d corto=%0d largo=%0d want 0 0 0",
                         w, n_rise, n_corto, n_largo);
            end
        end
    endtask

    task automatic test_release_glitch();
        int s;
        clear_stats();
        s = edge_n;
        drive(1'b0, 15);
        drive(1'b1, 2);
        drive(1'b0, 23);
        vectors++;
        if (n_fall != 0 || n_rise != 1) begin
            miscompares++;
            $display("FAIL relglitch_level: rises=%0d falls=%0d want 1 0", n_rise, n_fall);
        end
        // Hold count freezes for the 3 edges spent debouncing the glitch.
        vectors++;
        if (n_largo != 1 || largo_edge != s + 29) begin
            miscompares++;
            $display("FAIL relglitch_largo: count=%0d offset=%0d want 1 offset 29",
                     n_largo, largo_edge - s);
        end
        drive(1'b1, 15);
        vectors++;
        if (n_corto != 0 || n_largo != 1 || n_fall != 1) begin
            miscompares++;
            $display("FAIL relglitch_release: corto=%0d largo=%0d falls=%0d want 0 1 1",
                     n_corto, n_largo, n_fall);
        end
    endtask

    task automatic test_reset_mid_press();
        logic [2:0] outs;
        int s;
        clear_stats();
        drive(1'b0, 12);
        vectors++;
        if (presionado !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_pre: pres=%b want 1", presionado);
        end
        reset = 1'b1;
        #1;
        outs = {presionado, pulso_corto, pulso_largo};
        vectors++;
        if (outs !== 3'b000) begin
            miscompares++;
            $display("FAIL midreset_immediate: got %b want 000", outs);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        prev_pres = 1'b0;
        clear_stats();
        s = edge_n;
        drive(1'b0, 10);
        vectors++;
        if (rise_edge != s + 6 || n_corto != 0 || n_largo != 0) begin
            miscompares++;
            $display("FAIL midreset_rerise: offset=%0d corto=%0d largo=%0d want 6 0 0",
                     rise_edge - s, n_corto, n_largo);
        end
        drive(1'b1, 15);
    endtask

    task automatic test_exclusion();
        vectors++;
        if (n_both != 0) begin
            miscompares++;
            $display("FAIL pulse_exclusion: got %0d overlaps want 0", n_both);
        end
    endtask

    initial begin
        reset = 1'b1;
        boton_in = 1'b1;
        clear_stats();
        test_reset();
        test_short_press();
        test_long_press();
        test_glitches();
        test_release_glitch();
        test_exclusion();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
